// File: rtl/des3_cbc_ctrl.sv
// rtl/des3_cbc_ctrl.sv - CBC-mode block sequencer for a shared 3DES encrypt/decrypt engine
module des3_cbc_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_decrypt,
    input  logic [63:0]      cfg_iv,
    input  logic [CNT_W-1:0] cfg_nblocks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             eng_start,
    output logic             eng_decrypt,
    output logic [63:0]      eng_data,
    input  logic [63:0]      eng_result,
    input  logic             eng_done,
    output logic             busy,
    output logic             err_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_OUT     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        chain_q, chain_d;
    logic [63:0]        blk_q, blk_d;
    logic [63:0]        eng_data_q, eng_data_d;
    logic [63:0]        out_data_q, out_data_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mode_q, mode_d;
    logic               err_q, err_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            chain_q     <= '0;
            blk_q       <= '0;
            eng_data_q  <= '0;
            out_data_q  <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            blk_q       <= blk_d;
            eng_data_q  <= eng_data_d;
            out_data_q  <= out_data_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chain_d     = chain_q;
        blk_d       = blk_q;
        eng_data_d  = eng_data_q;
        out_data_d  = out_data_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        mode_d      = mode_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    chain_d     = cfg_iv;
                    mode_d      = cfg_decrypt;
                    remaining_d = cfg_nblocks;
                    err_d       = 1'b0;
                    if (cfg_nblocks != '0) state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    blk_d      = in_data;
                    eng_data_d = mode_q ? in_data : (in_data ^ chain_q);
                    state_d    = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_done) begin
                    out_data_d = mode_q ? (eng_result ^ chain_q) : eng_result;
                    chain_d    = mode_q ? blk_q : eng_result;
                    state_d    = S_OUT;
                end else if (timer_q == TMR_W'(TIMEOUT - 2)) begin
                    // Timer would reach TIMEOUT-1 on this edge: abandon the message.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == CNT_W'(1)) ? S_IDLE : S_WAIT_IN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;
        eng_start   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            S_WAIT_IN: in_ready  = 1'b1;
            S_START:   eng_start = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (remaining_q == CNT_W'(1));
            end
            default: ;
        endcase
        eng_decrypt = mode_q;
        eng_data    = eng_data_q;
        out_data    = out_data_q;
        err_timeout = err_q;
    end

endmodule

// File: doc/des3_cbc_ctrl.md
Name: des3_cbc_ctrl

Overview:
Sequences a shared 3DES engine (encrypt and decrypt cores behind one start/done interface) through multi-block messages in CBC mode. Handles the chaining XOR, IV loading and block counting. Exposes valid/ready streams for the message configuration, input blocks and output blocks. Sits between the host/DMA stream logic and the 3DES encrypt/decrypt cores; keys are supplied to the cores directly and are not handled here.

Parameters:
TIMEOUT, 1024, max cycles from eng_start to eng_done before the message is abandoned
CNT_W, 16, width of the block counter

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  message config offered
cfg_ready  out  1  controller accepts config (IDLE only)
cfg_decrypt  in  1  0 = CBC encrypt, 1 = CBC decrypt
cfg_iv  in  64  initialisation vector
cfg_nblocks  in  CNT_W  number of 64-bit blocks in message
in_valid  in  1  input block offered
in_ready  out  1  controller accepts input block
in_data  in  64  plaintext (enc) or ciphertext (dec)
out_valid  out  1  result block available
out_ready  in  1  downstream accepts result
out_data  out  64  result block
out_last  out  1  final block of message, qualified by out_valid
eng_start  out  1  one-cycle start pulse to 3DES engine
eng_decrypt  out  1  selects the decrypt core, held for the whole message
eng_data  out  64  engine input, held stable from eng_start until eng_done
eng_result  in  64  engine output, valid with eng_done
eng_done  in  1  engine completion pulse
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky engine-timeout flag

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every output and internal register is 0, except cfg_ready=1.
- Registers: chain[63:0], blk[63:0], remaining[CNT_W-1:0], mode, timer.
- IDLE: cfg_ready=1. On cfg_valid:
  - latch chain=cfg_iv, mode=cfg_decrypt (drives eng_decrypt), remaining=cfg_nblocks; clear err_timeout.
  - If cfg_nblocks==0, stay in IDLE and produce no output; otherwise go to WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid:
  - blk=in_data.
  - eng_data = in_data^chain (enc) or in_data (dec).
  - Go to START.
- START: eng_start=1 for exactly one cycle; timer=0; go to RUN.
- RUN: wait for eng_done; timer increments each cycle.
  - On eng_done (enc): out_data=eng_result; chain=eng_result.
  - On eng_done (dec): out_data=eng_result^chain; chain=blk.
  - After eng_done, go to OUT.
  - If timer reaches TIMEOUT-1 without eng_done: set err_timeout, go to IDLE, message abandoned, no output.
- OUT: out_valid=1; out_last=(remaining==1); out_data held stable. On out_ready: remaining decrements; go to IDLE if the new value is 0, else WAIT_IN.
- Latency: input accepted at cycle t → eng_start at t+1 → eng_done at t+1+L → out_valid at t+2+L.
- One block in flight at a time. in_ready=0 outside WAIT_IN; cfg_ready=0 outside IDLE.
- eng_done outside RUN is ignored, including a late done after a timeout or reset.
- Reset mid-message discards all state; no partial output is produced.
- out_valid/out_data follow AXI-style hold rules: once asserted, held until accepted.
- remaining never wraps; the OUT→IDLE exit occurs at 1→0.

Test Plan:
(Bench engine model: fixed 20-cycle latency, eng_result = ~eng_data for both modes.)
1. Enc, IV=0x0123456789ABCDEF, nblocks=2, P1=0, P2=0xFFFFFFFFFFFFFFFF → eng_data1=0x0123456789ABCDEF, C1=0xFEDCBA9876543210; eng_data2=0x0123456789ABCDEF, C2=0xFEDCBA9876543210, out_last only on C2; out_valid 22 cycles after each input accept.
2. Dec, same IV, C1/C2 from test 1 → out 0x0000000000000000 then 0xFFFFFFFFFFFFFFFF; eng_decrypt=1 throughout; busy low after last accept.
3. Hold out_ready=0 for 5 cycles at block 1 → out_valid and out_data stable, in_ready=0, eng_start not re-pulsed; accept → continues normally.
4. TIMEOUT=64, engine never asserts done → err_timeout=1 at 64 cycles after eng_start, state IDLE, cfg_ready=1; a late eng_done is ignored; next cfg_valid clears err_timeout.
5. cfg_nblocks=0 → cfg accepted, in_ready stays 0, no eng_start, busy stays 0.
6. rst_n low during RUN → all outputs 0 (cfg_ready 1) immediately; eng_done after release produces no out_valid.
